if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 5-stage RV32I pipeline: owns the program counter, selects the next PC from the `NPCOp`/`PC_Write` controls issued by the hazard unit, drives the instruction-memory address, and holds the IF/ID pipeline register, applying `IF_ID_Write` (hold) and `IF_ID_Flush` (bubble). It sits directly upstream of decode and downstream of the hazard unit. It also keeps stall/flush event counters and a sticky misaligned-target flag for debug.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INST`, 32'h0000_0013, instruction (`addi x0,x0,0`) inserted into IF/ID on flush and reset.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `PC_Write`  in  1  from hazard unit; 1 = PC may advance.
- `NPCOp`  in  3  next-PC select: 000 PC+4, 001 branch target, 010 jal target, 100 jalr target, 111 hold.
- `IF_ID_Write`  in  1  1 = load IF/ID register with fetched instruction.
- `IF_ID_Flush`  in  1  1 = load IF/ID with bubble; overrides `IF_ID_Write`.
- `EX_PC`  in  32  PC of the control-transfer instruction in EX.
- `EX_imm`  in  32  sign-extended immediate of that instruction.
- `EX_rs1`  in  32  forwarded rs1 value (jalr base).
- `imem_addr`  out  32  instruction-memory address (= current PC, combinational).
- `imem_rdata`  in  32  instruction word, valid same cycle as `imem_addr` (asynchronous read).
- `IF_ID_PC`  out  32  registered PC of instruction in ID.
- `IF_ID_PC4`  out  32  registered PC+4 (link value for jal/jalr).
- `IF_ID_inst`  out  32  registered instruction.
- `IF_ID_valid`  out  1  1 = IF/ID holds a real instruction, 0 = bubble.
- `stall_cnt`  out  32  cycles with `PC_Write`=0 or `NPCOp`=111, outside reset.
- `flush_cnt`  out  32  cycles with `IF_ID_Flush`=1, outside reset.
- `misalign`  out  1  sticky: a redirect target had bits [1:0] ≠ 00.

## Operation
- Next-PC: 000 → PC+4; 001 and 010 → `EX_PC`+`EX_imm`; 100 → (`EX_rs1`+`EX_imm`) & ~32'h1; 111 → PC; undefined codes (011,101,110) → PC+4. All additions modulo 2^32 (wrap, no carry out).
- PC register loads next-PC only when `PC_Write`=1 and `NPCOp`≠111; otherwise holds.
- IF/ID update priority: `rst` > `IF_ID_Flush` > `IF_ID_Write` > hold.
  - Flush: `IF_ID_inst`=`NOP_INST`, `IF_ID_valid`=0, `IF_ID_PC`/`IF_ID_PC4` = 0.
  - Write: `IF_ID_PC`=PC, `IF_ID_PC4`=PC+4, `IF_ID_inst`=`imem_rdata`, `IF_ID_valid`=1.
  - Hold: all IF/ID fields unchanged (load-use stall, hazard-unit default case).
- `misalign` sets when PC is updated with a redirect (001/010/100) whose target[1:0] ≠ 00 (for jalr, bit 1 only after masking); cleared only by `rst`. Misaligned target is still loaded.
- Counters increment by 1 per qualifying cycle, wrap from 32'hFFFF_FFFF to 0; a cycle may increment both.

## Timing
- Reset (synchronous, takes effect on the edge where `rst`=1): PC=`RESET_PC`, `IF_ID_inst`=`NOP_INST`, `IF_ID_valid`=0, `IF_ID_PC`=0, `IF_ID_PC4`=0, counters=0, `misalign`=0. `imem_addr`=`RESET_PC` the cycle after. Reset mid-stall or mid-flush discards all in-flight state.
- First real instruction appears in IF/ID one edge after `rst` deasserts with `IF_ID_Write`=1.
- Redirect latency: `NPCOp` redirect sampled at edge N → `imem_addr`=target after edge N; the wrong-path instruction is simultaneously replaced by a bubble via `IF_ID_Flush`; target instruction in IF/ID after edge N+1.
- Simultaneous `IF_ID_Flush`=1 and `IF_ID_Write`=1: flush wins.
- Load-use stall (`PC_Write`=0, `IF_ID_Write`=0): PC and IF/ID both frozen exactly one cycle per asserted cycle; `stall_cnt` +1.

## Test plan
- Reset then 4 cycles NPCOp=000, PC_Write=1, IF_ID_Write=1, `RESET_PC`=0 → `imem_addr` 0,4,8,C; `IF_ID_PC` follows one cycle later, `IF_ID_valid`=1.
- Load-use stall: at PC=0x10 drive PC_Write=0, NPCOp=111, IF_ID_Write=0 for 1 cycle → PC stays 0x10, IF/ID unchanged, `stall_cnt`=1, then resumes at 0x14.
- Taken branch: EX_PC=0x20, EX_imm=0xFFFF_FFF0, NPCOp=001, Flush=1 → PC=0x10, IF/ID = NOP, valid=0, `flush_cnt`=1.
- jalr: EX_rs1=0x103, EX_imm=4, NPCOp=100 → PC=0x106, `misalign`=1 and stays 1 until `rst`.
- Flush and Write both 1 → IF/ID = NOP; PC wrap: PC=0xFFFF_FFFC, NPCOp=000 → PC=0.
- Assert `rst` during a stall with counters nonzero → next cycle PC=`RESET_PC`, counters 0, valid 0.

Source files
------------

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage of a 5-stage RV32I pipeline. It owns the program
//   counter and selects the next PC from the hazard-unit controls. It drives
//   the instruction-memory address, which has an asynchronous read, and it
//   holds the IF/ID pipeline register, which supports hold and bubble. It also
//   keeps debug counters for stall and flush cycles, plus a sticky flag for
//   misaligned redirect targets.
//
// Handshake semantics: there is no valid/ready pair. PC_Write and IF_ID_Write
//   act as enables sampled on the rising edge. IF_ID_Flush overrides
//   IF_ID_Write. IF_ID_valid marks whether IF/ID holds a real instruction.
//
// Ports
//   clk, rst       : clock; synchronous active-high reset
//   PC_Write       : 1 = PC may advance
//   NPCOp[2:0]     : 000 PC+4, 001 branch, 010 jal, 100 jalr, 111 hold,
//                    other codes PC+4
//   IF_ID_Write    : load IF/ID with the fetched instruction
//   IF_ID_Flush    : load IF/ID with a bubble (wins over IF_ID_Write)
//   EX_PC, EX_imm  : PC and immediate of the control-transfer instr in EX
//   EX_rs1         : forwarded jalr base
//   imem_addr      : instruction-memory address (= current PC)
//   imem_rdata     : instruction word for imem_addr, same cycle
//   IF_ID_*        : pipeline register towards decode
//   stall_cnt      : cycles with PC_Write=0 or NPCOp=111
//   flush_cnt      : cycles with IF_ID_Flush=1
//   misalign       : sticky, a redirect target had non-zero bits [1:0]
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_Write,
  input  logic [2:0]  NPCOp,
  input  logic        IF_ID_Write,
  input  logic        IF_ID_Flush,
  input  logic [31:0] EX_PC,
  input  logic [31:0] EX_imm,
  input  logic [31:0] EX_rs1,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_PC4,
  output logic [31:0] IF_ID_inst,
  output logic        IF_ID_valid,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic        misalign
);

  localparam logic [2:0] NPC_PC4  = 3'b000;
  localparam logic [2:0] NPC_BR   = 3'b001;
  localparam logic [2:0] NPC_JAL  = 3'b010;
  localparam logic [2:0] NPC_JALR = 3'b100;
  localparam logic [2:0] NPC_HOLD = 3'b111;

  logic [31:0] r_pc;
  logic [31:0] r_if_id_pc;
  logic [31:0] r_if_id_pc4;
  logic [31:0] r_if_id_inst;
  logic        r_if_id_valid;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
  logic        r_misalign;

  logic [31:0] w_pc4;
  logic [31:0] w_br_target;
  logic [31:0] w_jalr_target;
  logic [31:0] w_npc;
  logic        w_redirect;
  logic        w_pc_load;
  logic        w_stall;

  // All adders wrap modulo 2^32; carry-out is intentionally dropped.
  assign w_pc4         = r_pc + 32'd4;
  assign w_br_target   = EX_PC + EX_imm;
  assign w_jalr_target = (EX_rs1 + EX_imm) & ~32'h1;

  always_comb begin
    w_npc      = w_pc4;
    w_redirect = 1'b0;
    case (NPCOp)
      NPC_PC4:  w_npc = w_pc4;
      NPC_BR,
      NPC_JAL: begin
        w_npc      = w_br_target;
        w_redirect = 1'b1;
      end
      NPC_JALR: begin
        w_npc      = w_jalr_target;
        w_redirect = 1'b1;
      end
      NPC_HOLD: w_npc = r_pc;
      default:  w_npc = w_pc4;  // undefined codes fall through to sequential
    endcase
  end

  assign w_pc_load = PC_Write && (NPCOp != NPC_HOLD);
  assign w_stall   = !w_pc_load;

  // Program counter, misalignment flag and event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_misalign  <= 1'b0;
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (w_pc_load) begin
        r_pc <= w_npc;
        // The target is loaded even when it is misaligned; only the flag records it.
        if (w_redirect && (w_npc[1:0] != 2'b00)) begin
          r_misalign <= 1'b1;
        end
      end
      if (w_stall) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (IF_ID_Flush) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  // IF/ID register: priority is reset > flush > write > hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_id_pc    <= 32'd0;
      r_if_id_pc4   <= 32'd0;
      r_if_id_inst  <= NOP_INST;
      r_if_id_valid <= 1'b0;
    end else if (IF_ID_Flush) begin
      r_if_id_pc    <= 32'd0;
      r_if_id_pc4   <= 32'd0;
      r_if_id_inst  <= NOP_INST;
      r_if_id_valid <= 1'b0;
    end else if (IF_ID_Write) begin
      r_if_id_pc    <= r_pc;
      r_if_id_pc4   <= w_pc4;
      r_if_id_inst  <= imem_rdata;
      r_if_id_valid <= 1'b1;
    end
  end

  assign imem_addr   = r_pc;
  assign IF_ID_PC    = r_if_id_pc;
  assign IF_ID_PC4   = r_if_id_pc4;
  assign IF_ID_inst  = r_if_id_inst;
  assign IF_ID_valid = r_if_id_valid;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;
  assign misalign    = r_misalign;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] MEM_KEY = 32'hDEAD_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        PC_Write;
  logic [2:0]  NPCOp;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic [31:0] EX_PC;
  logic [31:0] EX_imm;
  logic [31:0] EX_rs1;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_PC;
  logic [31:0] IF_ID_PC4;
  logic [31:0] IF_ID_inst;
  logic        IF_ID_valid;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic        misalign;

  // Instruction memory model: each word is its address XOR a fixed key.
  assign imem_rdata = imem_addr ^ MEM_KEY;

  if_stage dut (
    .clk(clk), .rst(rst), .PC_Write(PC_Write), .NPCOp(NPCOp),
    .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .EX_PC(EX_PC), .EX_imm(EX_imm), .EX_rs1(EX_rs1),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .IF_ID_PC(IF_ID_PC), .IF_ID_PC4(IF_ID_PC4), .IF_ID_inst(IF_ID_inst),
    .IF_ID_valid(IF_ID_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .misalign(misalign)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pcw, input logic [2:0] op,
                       input logic wr, input logic fl);
    PC_Write    = pcw;
    NPCOp       = op;
    IF_ID_Write = wr;
    IF_ID_Flush = fl;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc,
                            input logic [31:0] inst, input logic valid);
    check({tag, "_pc"},    IF_ID_PC,   pc);
    check({tag, "_pc4"},   IF_ID_PC4,  valid ? pc + 32'd4 : 32'd0);
    check({tag, "_inst"},  IF_ID_inst, inst);
    check({tag, "_valid"}, {31'd0, IF_ID_valid}, {31'd0, valid});
  endtask

  initial begin
    rst = 1'b1;
    EX_PC = 32'd0; EX_imm = 32'd0; EX_rs1 = 32'd0;
    drive(1'b1, 3'b000, 1'b1, 1'b0);
    tick(); tick();

    // Reset state
    check("rst_addr", imem_addr, 32'h0);
    check_ifid("rst", 32'h0, NOP, 1'b0);
    check("rst_stall", stall_cnt, 32'd0);
    check("rst_flush", flush_cnt, 32'd0);
    check("rst_mis", {31'd0, misalign}, 32'd0);

    // Sequential fetch: imem_addr 0,4,8,C and IF/ID trails by one cycle
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("seq_addr", imem_addr, 32'(4 * i));
      tick();
      check_ifid("seq", 32'(4 * i), 32'(4 * i) ^ MEM_KEY, 1'b1);
    end
    check("seq_end_addr", imem_addr, 32'h10);

    // Load-use stall for one cycle at PC=0x10
    drive(1'b0, 3'b111, 1'b0, 1'b0);
    tick();
    check("stall_addr", imem_addr, 32'h10);
    check_ifid("stall", 32'hC, 32'hC ^ MEM_KEY, 1'b1);
    check("stall_cnt1", stall_cnt, 32'd1);
    drive(1'b1, 3'b000, 1'b1, 1'b0);
    tick();
    check("resume_addr", imem_addr, 32'h14);
    check_ifid("resume", 32'h10, 32'h10 ^ MEM_KEY, 1'b1);
    check("resume_stall", stall_cnt, 32'd1);

    // Taken branch with flush and write both asserted: flush wins
    EX_PC = 32'h20; EX_imm = 32'hFFFF_FFF0;
    drive(1'b1, 3'b001, 1'b1, 1'b1);
    tick();
    check("br_addr", imem_addr, 32'h10);
    check_ifid("br", 32'h0, NOP, 1'b0);
    check("br_flush", flush_cnt, 32'd1);
    check("br_mis", {31'd0, misalign}, 32'd0);
    drive(1'b1, 3'b000, 1'b1, 1'b0);
    tick();
    check("br_tgt_addr", imem_addr, 32'h14);
    check_ifid("br_tgt", 32'h10, 32'h10 ^ MEM_KEY, 1'b1);

    // jal redirect
    EX_PC = 32'h100; EX_imm = 32'h40;
    drive(1'b1, 3'b010, 1'b1, 1'b1);
    tick();
    check("jal_addr", imem_addr, 32'h140);
    check("jal_flush", flush_cnt, 32'd2);

    // Undefined code 011 behaves as PC+4
    drive(1'b1, 3'b011, 1'b1, 1'b0);
    tick();
    check("undef_addr", imem_addr, 32'h144);
    check_ifid("undef", 32'h140, 32'h140 ^ MEM_KEY, 1'b1);

    // jalr to 0x103+4 = 0x107, masked to 0x106 -> misaligned
    EX_rs1 = 32'h103; EX_imm = 32'h4;
    drive(1'b1, 3'b100, 1'b1, 1'b1);
    tick();
    check("jalr_addr", imem_addr, 32'h106);
    check("jalr_mis", {31'd0, misalign}, 32'd1);
    check("jalr_flush", flush_cnt, 32'd3);
    drive(1'b1, 3'b000, 1'b1, 1'b0);
    tick();
    check("jalr_next", imem_addr, 32'h10A);
    check_ifid("jalr_tgt", 32'h106, 32'h106 ^ MEM_KEY, 1'b1);
    check("mis_sticky", {31'd0, misalign}, 32'd1);

    // PC wrap: jump to 0xFFFF_FFFC, then PC+4 wraps to 0
    EX_PC = 32'hFFFF_FFF0; EX_imm = 32'hC;
    drive(1'b1, 3'b010, 1'b1, 1'b1);
    tick();
    check("wrap_tgt", imem_addr, 32'hFFFF_FFFC);
    drive(1'b1, 3'b000, 1'b1, 1'b0);
    tick();
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_ifid_pc", IF_ID_PC, 32'hFFFF_FFFC);
    check("wrap_ifid_pc4", IF_ID_PC4, 32'h0);

    // PC_Write=0 with flush: counts as both a stall and a flush
    drive(1'b0, 3'b000, 1'b1, 1'b1);
    tick();
    check("both_addr", imem_addr, 32'h0);
    check("both_stall", stall_cnt, 32'd2);
    check("both_flush", flush_cnt, 32'd5);
    check("both_valid", {31'd0, IF_ID_valid}, 32'd0);

    // Reset in the middle of a stall with nonzero counters
    drive(1'b0, 3'b111, 1'b0, 1'b0);
    tick();
    check("pre_rst_stall", stall_cnt, 32'd3);
    rst = 1'b1;
    tick();
    check("mid_rst_addr", imem_addr, 32'h0);
    check("mid_rst_stall", stall_cnt, 32'd0);
    check("mid_rst_flush", flush_cnt, 32'd0);
    check("mid_rst_valid", {31'd0, IF_ID_valid}, 32'd0);
    check("mid_rst_inst", IF_ID_inst, NOP);
    check("mid_rst_mis", {31'd0, misalign}, 32'd0);
    rst = 1'b0;
    drive(1'b1, 3'b000, 1'b1, 1'b0);
    tick();
    check_ifid("post_rst", 32'h0, MEM_KEY, 1'b1);
    check("post_rst_addr", imem_addr, 32'h4);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
